mc_seq_regs: RTL and testbench
==============================

// Module: mc_seq_regs
// PURPOSE
//  Architectural/micro-architectural register file wrapped around the multi-cycle control unit:
//   - holds uPC and feeds it back to the controller
//   - holds IR (INSTR to controller/decoder), PC, ALU_OUT and MDR
//   - computes and commits next-PC
//  Consumes the controller's Updated_uPC, PCWrite, isBranch, PCSrc, IRWrite, ALUWrite, IorD and INSTR_FINISH.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value after reset
//  UPC_W      3              width of uPC / Updated_uPC
// PORTS
//  CLK          in   1      clock, all state on rising edge
//  RSTn         in   1      asynchronous active-low reset
//  Updated_uPC  in   UPC_W  next micro-state from controller
//  IRWrite      in   1      capture I_MEM_DI into IR
//  ALUWrite     in   1      EX cycle: capture ALU_RESULT into ALU_OUT, latch next-PC decision
//  PCWrite      in   1      commit latched next-PC into PC
//  isBranch     in   1      current EX is a conditional branch
//  PCSrc        in   2      00 PC+4, 01 ALU_RESULT, 10 ALU_RESULT&~1, 11 branch
//  IorD         in   1      0: MEM_ADDR=PC, 1: MEM_ADDR=ALU_OUT
//  MemRead      in   1      capture D_MEM_DI into MDR when IorD=1
//  INSTR_FINISH in   1      instruction retires this cycle
//  I_MEM_DI     in   32     instruction memory data
//  D_MEM_DI     in   32     data memory data
//  ALU_RESULT   in   32     ALU output (branch condition in bit 0 when isBranch)
//  IMM          in   32     sign-extended immediate of current IR
//  uPC          out  UPC_W  current micro-state
//  INSTR        out  32     instruction register
//  PC           out  32     program counter
//  PC_PLUS4     out  32     PC+4 (comb), RF write-back source for JAL/JALR
//  ALU_OUT      out  32     registered ALU result
//  MDR          out  32     registered memory data
//  MEM_ADDR     out  32     IorD ? ALU_OUT : PC (comb)
//  NUM_INST     out  32     retired-instruction count (only with macro)
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-instruction): uPC=0, INSTR=0, PC=RESET_PC, ALU_OUT=0, MDR=0,
//    pcsrc_q=00, taken_q=0, target_q=0, NUM_INST=0. First cycle after release is IF.
//  - uPC <= Updated_uPC every edge. Values 5..7 are passed through unchanged; controller owns legality.
//  - IRWrite=1: INSTR <= I_MEM_DI. IRWrite=0: hold.
//  - ALUWrite=1 (EX), the following are latched in the same edge:
//      ALU_OUT <= ALU_RESULT; pcsrc_q <= PCSrc; taken_q <= isBranch & ALU_RESULT[0];
//      target_q <= PC + IMM.
//  - MemRead & IorD: MDR <= D_MEM_DI.
//  - PCWrite=1: PC <= next_pc, selected on pcsrc_q:
//      00 -> PC+4
//      01 -> ALU_OUT
//      10 -> ALU_OUT & 32'hFFFF_FFFE
//      11 -> taken_q ? target_q : PC+4
//  - Latched decision survives until the next ALUWrite. PCWrite with no EX since reset gives PC+4.
//  - Arithmetic is modulo 2^32: PC=32'hFFFF_FFFC, +4 -> 0. No alignment trap.
//  - Simultaneous events:
//      IRWrite & PCWrite: IR takes I_MEM_DI, PC advances, both in the same edge.
//      ALUWrite & PCWrite: PC uses the pre-edge pcsrc_q/taken_q/target_q/ALU_OUT (old values).
//  - MEM_ADDR and PC_PLUS4 are purely combinational; all other outputs are registered.
// CONFIGURATION
//  MC_INSTR_COUNT_EN defined:
//    NUM_INST increments by 1 on each edge with INSTR_FINISH=1; wraps from 2^32-1 to 0.
//  MC_INSTR_COUNT_EN undefined:
//    NUM_INST tied to 0, counter not synthesised.
// STRUCTURE
//  Shared package/header: PCSrc encodings (PCSRC_PC4, PCSRC_ALU, PCSRC_JALR, PCSRC_BR); uPC state
//  constants (UPC_IF=0, UPC_ID=1, UPC_EX=2, UPC_MEM=3, UPC_WB=4); RESET_PC default.
//  One sub-module: mc_next_pc (combinational next-PC select from pcsrc_q/taken_q/target_q/ALU_OUT/PC).
// TESTING
//  1 Reset: RSTn=0 mid-EX with PC=0x40 -> all outputs reset immediately (async); PC=RESET_PC after release.
//  2 Sequential: EX with PCSrc=00, then PCWrite -> PC 0x100 -> 0x104; PC 0xFFFFFFFC -> 0x0.
//  3 Branch: PC=0x20, IMM=-8, isBranch=1.
//      ALU_RESULT=1 then PCWrite -> PC=0x18.
//      ALU_RESULT=0 -> PC=0x24.
//  4 JALR: PCSrc=10, ALU_RESULT=0x1235 then PCWrite -> PC=0x1234; JAL PCSrc=01, 0x80 -> PC=0x80.
//  5 Same-edge: ALUWrite & PCWrite -> PC uses old latched decision; IRWrite & PCWrite -> INSTR=I_MEM_DI and PC updated.
//  6 Counter: 3 INSTR_FINISH pulses -> NUM_INST=3 with MC_INSTR_COUNT_EN; stays 0 without it.

Source files
------------

// File: rtl/mc_seq_regs_pkg.sv
// Shared constants for the multi-cycle sequencer register file: next-PC source encodings,
// micro-state numbering and the default reset PC.
package mc_seq_regs_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int unsigned UPC_W_DEFAULT    = 3;

   typedef logic [1:0] pcsrc_t;

   localparam pcsrc_t PCSRC_PC4  = 2'b00;
   localparam pcsrc_t PCSRC_ALU  = 2'b01;
   localparam pcsrc_t PCSRC_JALR = 2'b10;
   localparam pcsrc_t PCSRC_BR   = 2'b11;

   localparam logic [2:0] UPC_IF  = 3'd0;
   localparam logic [2:0] UPC_ID  = 3'd1;
   localparam logic [2:0] UPC_EX  = 3'd2;
   localparam logic [2:0] UPC_MEM = 3'd3;
   localparam logic [2:0] UPC_WB  = 3'd4;

   // JALR targets drop bit 0 of the computed address.
   function automatic logic [31:0] jalr_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFE;
   endfunction

endpackage

// File: rtl/mc_seq_regs_if.sv
// Controller/datapath bundle around the sequencer register file. The master side drives the
// controller strobes and datapath inputs; the slave side (mc_seq_regs) drives the register outputs.
interface mc_seq_regs_if
   import mc_seq_regs_pkg::*;
#(
   parameter int unsigned UPC_W = UPC_W_DEFAULT
);
   logic [UPC_W-1:0] Updated_uPC;
   logic             IRWrite;
   logic             ALUWrite;
   logic             PCWrite;
   logic             isBranch;
   logic [1:0]       PCSrc;
   logic             IorD;
   logic             MemRead;
   logic             INSTR_FINISH;
   logic [31:0]      I_MEM_DI;
   logic [31:0]      D_MEM_DI;
   logic [31:0]      ALU_RESULT;
   logic [31:0]      IMM;
   logic [UPC_W-1:0] uPC;
   logic [31:0]      INSTR;
   logic [31:0]      PC;
   logic [31:0]      PC_PLUS4;
   logic [31:0]      ALU_OUT;
   logic [31:0]      MDR;
   logic [31:0]      MEM_ADDR;
   logic [31:0]      NUM_INST;

   modport master (
      output Updated_uPC, IRWrite, ALUWrite, PCWrite, isBranch, PCSrc, IorD, MemRead,
             INSTR_FINISH, I_MEM_DI, D_MEM_DI, ALU_RESULT, IMM,
      input  uPC, INSTR, PC, PC_PLUS4, ALU_OUT, MDR, MEM_ADDR, NUM_INST
   );

   modport slave (
      input  Updated_uPC, IRWrite, ALUWrite, PCWrite, isBranch, PCSrc, IorD, MemRead,
             INSTR_FINISH, I_MEM_DI, D_MEM_DI, ALU_RESULT, IMM,
      output uPC, INSTR, PC, PC_PLUS4, ALU_OUT, MDR, MEM_ADDR, NUM_INST
   );

endinterface

// File: rtl/mc_seq_regs_next_pc.sv
// Combinational next-PC select driven by the decision latched in the last EX cycle.
module mc_next_pc
   import mc_seq_regs_pkg::*;
(
   input  pcsrc_t      pcsrc,
   input  logic        taken,
   input  logic [31:0] target,
   input  logic [31:0] alu_out,
   input  logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc
);

   assign pc_plus4 = pc + 32'd4;

   // Select the committed PC source; a not-taken branch falls through to PC+4.
   always_comb begin
      next_pc = pc_plus4;
      case (pcsrc)
         PCSRC_PC4:  next_pc = pc_plus4;
         PCSRC_ALU:  next_pc = alu_out;
         PCSRC_JALR: next_pc = jalr_align(alu_out);
         PCSRC_BR: begin
            if (taken) begin
               next_pc = target;
            end else begin
               next_pc = pc_plus4;
            end
         end
         default:    next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/mc_seq_regs.sv
// Sequencer register file: uPC, IR, PC, ALU_OUT, MDR and the latched next-PC decision.
// Optional retired-instruction counter enabled by defining MC_INSTR_COUNT_EN.
module mc_seq_regs
   import mc_seq_regs_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned UPC_W    = UPC_W_DEFAULT
)
(
   input logic          CLK,
   input logic          RSTn,
   mc_seq_regs_if.slave bus
);

   logic [UPC_W-1:0] upc_r;
   logic [31:0]      instr_r;
   logic [31:0]      pc_r;
   logic [31:0]      alu_out_r;
   logic [31:0]      mdr_r;
   pcsrc_t           pcsrc_r;
   logic             taken_r;
   logic [31:0]      target_r;
   logic [31:0]      next_pc_s;
   logic [31:0]      pc_plus4_s;

   mc_next_pc u_next_pc (
      .pcsrc    (pcsrc_r),
      .taken    (taken_r),
      .target   (target_r),
      .alu_out  (alu_out_r),
      .pc       (pc_r),
      .pc_plus4 (pc_plus4_s),
      .next_pc  (next_pc_s)
   );

   // Micro-state follows the controller every cycle, illegal codes included.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         upc_r <= {UPC_W{1'b0}};
      end else begin
         upc_r <= bus.Updated_uPC;
      end
   end

   // Instruction register and PC; PC commits from the pre-edge latched decision.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         instr_r <= 32'h0000_0000;
         pc_r    <= RESET_PC;
      end else begin
         if (bus.IRWrite) begin
            instr_r <= bus.I_MEM_DI;
         end
         if (bus.PCWrite) begin
            pc_r <= next_pc_s;
         end
      end
   end

   // EX-cycle capture of the ALU result and the next-PC decision.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         alu_out_r <= 32'h0000_0000;
         pcsrc_r   <= PCSRC_PC4;
         taken_r   <= 1'b0;
         target_r  <= 32'h0000_0000;
      end else if (bus.ALUWrite) begin
         alu_out_r <= bus.ALU_RESULT;
         pcsrc_r   <= bus.PCSrc;
         taken_r   <= bus.isBranch & bus.ALU_RESULT[0];
         target_r  <= pc_r + bus.IMM;
      end
   end

   // Memory data register loads only on data-side reads.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         mdr_r <= 32'h0000_0000;
      end else if (bus.MemRead && bus.IorD) begin
         mdr_r <= bus.D_MEM_DI;
      end
   end

`ifdef MC_INSTR_COUNT_EN
   logic [31:0] num_inst_r;

   // Retired-instruction counter, wraps modulo 2^32.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         num_inst_r <= 32'h0000_0000;
      end else if (bus.INSTR_FINISH) begin
         num_inst_r <= num_inst_r + 32'd1;
      end
   end

   assign bus.NUM_INST = num_inst_r;
`else
   assign bus.NUM_INST = 32'h0000_0000;
`endif

   assign bus.uPC      = upc_r;
   assign bus.INSTR    = instr_r;
   assign bus.PC       = pc_r;
   assign bus.PC_PLUS4 = pc_plus4_s;
   assign bus.ALU_OUT  = alu_out_r;
   assign bus.MDR      = mdr_r;
   assign bus.MEM_ADDR = bus.IorD ? alu_out_r : pc_r;

endmodule

// File: tb/tb_mc_seq_regs.sv
// Directed bench for mc_seq_regs: reset, next-PC sources, wrap, same-edge events, MDR, counter.
module tb_mc_seq_regs;

   logic CLK;
   logic RSTn;
   int   passed;
   int   total;

   mc_seq_regs_if #(.UPC_W(3)) bus ();

   mc_seq_regs #(.RESET_PC(32'h0000_0000), .UPC_W(3)) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus.slave)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
      bus.IRWrite      = 1'b0;
      bus.ALUWrite     = 1'b0;
      bus.PCWrite      = 1'b0;
      bus.MemRead      = 1'b0;
      bus.INSTR_FINISH = 1'b0;
      bus.isBranch     = 1'b0;
   endtask

   task automatic ex(input logic [1:0] src, input logic br, input logic [31:0] alu, input logic [31:0] imm);
      bus.ALUWrite   = 1'b1;
      bus.PCSrc      = src;
      bus.isBranch   = br;
      bus.ALU_RESULT = alu;
      bus.IMM        = imm;
      tick();
   endtask

   task automatic pcw();
      bus.PCWrite = 1'b1;
      tick();
   endtask

   task automatic setpc(input logic [31:0] v);
      ex(2'b01, 1'b0, v, 32'h0000_0000);
      pcw();
   endtask

   initial begin
      passed           = 0;
      total            = 0;
      RSTn             = 1'b0;
      bus.Updated_uPC  = 3'd0;
      bus.IRWrite      = 1'b0;
      bus.ALUWrite     = 1'b0;
      bus.PCWrite      = 1'b0;
      bus.isBranch     = 1'b0;
      bus.PCSrc        = 2'b00;
      bus.IorD         = 1'b0;
      bus.MemRead      = 1'b0;
      bus.INSTR_FINISH = 1'b0;
      bus.I_MEM_DI     = 32'h0000_0000;
      bus.D_MEM_DI     = 32'h0000_0000;
      bus.ALU_RESULT   = 32'h0000_0000;
      bus.IMM          = 32'h0000_0000;
      @(negedge CLK);
      @(negedge CLK);
      RSTn = 1'b1;
      tick();

      chk("rst_upc", {29'd0, bus.uPC}, 32'd0);
      chk("rst_instr", bus.INSTR, 32'h0000_0000);
      chk("rst_pc", bus.PC, 32'h0000_0000);
      chk("rst_alu_out", bus.ALU_OUT, 32'h0000_0000);
      chk("rst_mdr", bus.MDR, 32'h0000_0000);
      chk("rst_num_inst", bus.NUM_INST, 32'h0000_0000);
      chk("rst_pc_plus4", bus.PC_PLUS4, 32'h0000_0004);
      chk("rst_mem_addr", bus.MEM_ADDR, 32'h0000_0000);

      pcw();
      chk("pcw_no_ex", bus.PC, 32'h0000_0004);

      setpc(32'h0000_0100);
      chk("jal_alu_out", bus.ALU_OUT, 32'h0000_0100);
      chk("jal_pc_0x100", bus.PC, 32'h0000_0100);
      ex(2'b00, 1'b0, 32'h0000_0555, 32'h0000_0000);
      pcw();
      chk("seq_pc_0x104", bus.PC, 32'h0000_0104);

      setpc(32'hFFFF_FFFC);
      chk("wrap_pc_plus4", bus.PC_PLUS4, 32'h0000_0000);
      ex(2'b00, 1'b0, 32'h0000_0000, 32'h0000_0000);
      pcw();
      chk("wrap_pc", bus.PC, 32'h0000_0000);

      setpc(32'h0000_0020);
      ex(2'b11, 1'b1, 32'h0000_0001, 32'hFFFF_FFF8);
      pcw();
      chk("br_taken", bus.PC, 32'h0000_0018);
      setpc(32'h0000_0020);
      ex(2'b11, 1'b1, 32'h0000_0000, 32'hFFFF_FFF8);
      pcw();
      chk("br_not_taken", bus.PC, 32'h0000_0024);
      pcw();
      chk("decision_held", bus.PC, 32'h0000_0028);
      ex(2'b11, 1'b0, 32'h0000_0001, 32'h0000_0010);
      pcw();
      chk("br_no_isbranch", bus.PC, 32'h0000_002C);

      ex(2'b10, 1'b0, 32'h0000_1235, 32'h0000_0000);
      pcw();
      chk("jalr_pc", bus.PC, 32'h0000_1234);
      ex(2'b01, 1'b0, 32'h0000_0080, 32'h0000_0000);
      pcw();
      chk("jal_pc_0x80", bus.PC, 32'h0000_0080);

      ex(2'b01, 1'b0, 32'h0000_0300, 32'h0000_0000);
      bus.PCWrite = 1'b1;
      ex(2'b00, 1'b0, 32'h0000_0500, 32'h0000_0000);
      chk("same_edge_pc_old", bus.PC, 32'h0000_0300);
      chk("same_edge_alu_new", bus.ALU_OUT, 32'h0000_0500);
      pcw();
      chk("same_edge_after", bus.PC, 32'h0000_0304);

      bus.I_MEM_DI = 32'hDEAD_BEEF;
      bus.IRWrite  = 1'b1;
      bus.PCWrite  = 1'b1;
      tick();
      chk("ir_pc_instr", bus.INSTR, 32'hDEAD_BEEF);
      chk("ir_pc_pc", bus.PC, 32'h0000_0308);
      bus.I_MEM_DI = 32'h1234_5678;
      tick();
      chk("ir_hold", bus.INSTR, 32'hDEAD_BEEF);

      bus.D_MEM_DI = 32'hCAFE_F00D;
      bus.MemRead  = 1'b1;
      tick();
      chk("mdr_iord0_hold", bus.MDR, 32'h0000_0000);
      bus.IorD    = 1'b1;
      bus.MemRead = 1'b1;
      tick();
      chk("mdr_load", bus.MDR, 32'hCAFE_F00D);
      chk("mem_addr_alu", bus.MEM_ADDR, 32'h0000_0500);
      bus.IorD = 1'b0;
      #1;
      chk("mem_addr_pc", bus.MEM_ADDR, 32'h0000_0308);

      bus.Updated_uPC = 3'd3;
      tick();
      chk("upc_3", {29'd0, bus.uPC}, 32'd3);
      bus.Updated_uPC = 3'd7;
      tick();
      chk("upc_7", {29'd0, bus.uPC}, 32'd7);
      bus.Updated_uPC = 3'd0;
      tick();

      for (int i = 0; i < 3; i++) begin
         bus.INSTR_FINISH = 1'b1;
         tick();
      end
      tick();
`ifdef MC_INSTR_COUNT_EN
      chk("num_inst_3", bus.NUM_INST, 32'd3);
`else
      chk("num_inst_off", bus.NUM_INST, 32'd0);
`endif

      setpc(32'h0000_0040);
      bus.Updated_uPC = 3'd2;
      tick();
      bus.ALUWrite   = 1'b1;
      bus.PCSrc      = 2'b01;
      bus.ALU_RESULT = 32'h0000_0999;
      #2;
      RSTn = 1'b0;
      #1;
      chk("async_pc", bus.PC, 32'h0000_0000);
      chk("async_upc", {29'd0, bus.uPC}, 32'd0);
      chk("async_instr", bus.INSTR, 32'h0000_0000);
      chk("async_alu_out", bus.ALU_OUT, 32'h0000_0000);
      chk("async_mdr", bus.MDR, 32'h0000_0000);
      chk("async_num_inst", bus.NUM_INST, 32'h0000_0000);
      @(negedge CLK);
      bus.ALUWrite    = 1'b0;
      bus.Updated_uPC = 3'd0;
      RSTn            = 1'b1;
      tick();
      chk("post_rst_pc", bus.PC, 32'h0000_0000);
      pcw();
      chk("post_rst_decision", bus.PC, 32'h0000_0004);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
